// File: rtl/kth_select_sorter_pkg.sv
// sort_pkg: shared types and helpers for the kth_select_sorter block.
//   state_e  : controller states (IDLE, SORT, TALLY)
//   key_gt   : strict greater-than on keys pre-extended to KEY_MAX_W bits,
//              signed or unsigned depending on signed_mode.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SORT  = 2'd1,
    TALLY = 2'd2
  } state_e;

  // Widest key the compare helper handles; callers extend their keys to this
  // width (sign- or zero-extension) before calling key_gt.
  localparam int KEY_MAX_W = 64;

  function automatic logic key_gt(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b,
                                  input logic                 signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/kth_select_sorter_if.sv
// kth_select_sorter_if: request/result bundle of the sort/select unit.
//   master : requester side (drives numbers, index, valid_in)
//   slave  : sorter side (drives ready/busy/valid_out and all results)
//   state_dbg exposes the sorter controller state for observation.
//
// Handshake: a request transfers on a rising clock edge where valid_in and
// ready_out are both 1. valid_in while ready_out is 0 is ignored (not queued).
// valid_out is a single-cycle strobe; result fields hold until the next result.
interface kth_select_sorter_if
  import sort_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8
) ();
  localparam int IDX_W = $clog2(N);

  logic [N-1:0][WIDTH-1:0] numbers;
  logic [IDX_W-1:0]        index;
  logic                    valid_in;
  logic                    ready_out;
  logic                    busy_out;
  logic                    valid_out;
  logic [N-1:0][WIDTH-1:0] sorted;
  logic [N-1:0][IDX_W-1:0] sorted_tag;
  logic [WIDTH-1:0]        nth_min;
  logic [IDX_W-1:0]        nth_tag;
  logic [IDX_W:0]          num_of_mins;
  state_e                  state_dbg;

  modport master (
    output numbers, index, valid_in,
    input  ready_out, busy_out, valid_out, sorted, sorted_tag,
           nth_min, nth_tag, num_of_mins, state_dbg
  );

  modport slave (
    input  numbers, index, valid_in,
    output ready_out, busy_out, valid_out, sorted, sorted_tag,
           nth_min, nth_tag, num_of_mins, state_dbg
  );
endinterface

// File: rtl/kth_select_sorter_cmp_swap.sv
// cmp_swap: combinational compare-exchange of two (key, tag) pairs.
//   lo_*_in / hi_*_in   : pair at the lower / upper position
//   lo_*_out / hi_*_out : pair after exchange (smaller key at lower position)
// Exchanges only when lower > upper strictly, so equal keys keep their order.
// WIDTH must not exceed sort_pkg::KEY_MAX_W.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDX_W  = 3,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] lo_key_in,
  input  logic [IDX_W-1:0] lo_tag_in,
  input  logic [WIDTH-1:0] hi_key_in,
  input  logic [IDX_W-1:0] hi_tag_in,
  output logic [WIDTH-1:0] lo_key_out,
  output logic [IDX_W-1:0] lo_tag_out,
  output logic [WIDTH-1:0] hi_key_out,
  output logic [IDX_W-1:0] hi_tag_out
);
  logic [KEY_MAX_W-1:0] lo_ext;
  logic [KEY_MAX_W-1:0] hi_ext;
  logic                 swap;

  always_comb begin
    if (SIGNED != 0) begin
      lo_ext = KEY_MAX_W'($signed(lo_key_in));
      hi_ext = KEY_MAX_W'($signed(hi_key_in));
    end else begin
      lo_ext = KEY_MAX_W'(lo_key_in);
      hi_ext = KEY_MAX_W'(hi_key_in);
    end
    swap       = key_gt(lo_ext, hi_ext, SIGNED != 0);
    lo_key_out = swap ? hi_key_in : lo_key_in;
    lo_tag_out = swap ? hi_tag_in : lo_tag_in;
    hi_key_out = swap ? lo_key_in : hi_key_in;
    hi_tag_out = swap ? lo_tag_in : hi_tag_in;
  end
endmodule

// File: rtl/kth_select_sorter.sv
// kth_select_sorter: N-key stable sorter with rank select.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : numbers/index/valid_in in; ready_out, busy_out,
//                    valid_out, sorted, sorted_tag, nth_min, nth_tag,
//                    num_of_mins, state_dbg out
// Flow: IDLE latches a request, SORT runs N odd-even transposition phases
// (one per cycle), TALLY registers the results and pulses valid_out.
module kth_select_sorter
  import sort_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  kth_select_sorter_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        phase_q, phase_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [WIDTH-1:0]        key_q [N];
  logic [WIDTH-1:0]        key_d [N];
  logic [IDX_W-1:0]        tag_q [N];
  logic [IDX_W-1:0]        tag_d [N];
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0] sorted_q, sorted_d;
  logic [N-1:0][IDX_W-1:0] sorted_tag_q, sorted_tag_d;
  logic [WIDTH-1:0]        nth_min_q, nth_min_d;
  logic [IDX_W-1:0]        nth_tag_q, nth_tag_d;
  logic [IDX_W:0]          mins_q, mins_d;

  // Both phase networks are always evaluated; the phase parity picks one.
  logic [WIDTH-1:0] even_key [N];
  logic [IDX_W-1:0] even_tag [N];
  logic [WIDTH-1:0] odd_key  [N];
  logic [IDX_W-1:0] odd_tag  [N];

  for (genvar p = 0; p < N/2; p++) begin : g_even
    cmp_swap #(.WIDTH(WIDTH), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_cs (
      .lo_key_in (key_q[2*p]),     .lo_tag_in (tag_q[2*p]),
      .hi_key_in (key_q[2*p+1]),   .hi_tag_in (tag_q[2*p+1]),
      .lo_key_out(even_key[2*p]),  .lo_tag_out(even_tag[2*p]),
      .hi_key_out(even_key[2*p+1]), .hi_tag_out(even_tag[2*p+1])
    );
  end

  for (genvar p = 0; p < N/2-1; p++) begin : g_odd
    cmp_swap #(.WIDTH(WIDTH), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_cs (
      .lo_key_in (key_q[2*p+1]),   .lo_tag_in (tag_q[2*p+1]),
      .hi_key_in (key_q[2*p+2]),   .hi_tag_in (tag_q[2*p+2]),
      .lo_key_out(odd_key[2*p+1]), .lo_tag_out(odd_tag[2*p+1]),
      .hi_key_out(odd_key[2*p+2]), .hi_tag_out(odd_tag[2*p+2])
    );
  end

  // End positions take no part in an odd phase.
  assign odd_key[0]   = key_q[0];
  assign odd_tag[0]   = tag_q[0];
  assign odd_key[N-1] = key_q[N-1];
  assign odd_tag[N-1] = tag_q[N-1];

  // Tally: key at the requested rank and how many keys are bit-equal to it.
  logic [WIDTH-1:0] sel_key;
  logic [IDX_W-1:0] sel_tag;
  logic [N-1:0]     eq_vec;
  logic [IDX_W:0]   eq_cnt;

  assign sel_key = key_q[index_q];
  assign sel_tag = tag_q[index_q];

  for (genvar g = 0; g < N; g++) begin : g_eq
    assign eq_vec[g] = (key_q[g] == sel_key);
  end

  always_comb begin
    eq_cnt = '0;
    for (int i = 0; i < N; i++) begin
      eq_cnt = eq_cnt + (IDX_W+1)'(eq_vec[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    index_d      = index_q;
    key_d        = key_q;
    tag_d        = tag_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    sorted_d     = sorted_q;
    sorted_tag_d = sorted_tag_q;
    nth_min_d    = nth_min_q;
    nth_tag_d    = nth_tag_q;
    mins_d       = mins_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          for (int i = 0; i < N; i++) begin
            key_d[i] = bus.numbers[i];
            tag_d[i] = IDX_W'(i);
          end
          index_d = bus.index;
          phase_d = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SORT;
        end
      end
      SORT: begin
        if (phase_q[0]) begin
          key_d = odd_key;
          tag_d = odd_tag;
        end else begin
          key_d = even_key;
          tag_d = even_tag;
        end
        phase_d = phase_q + 1'b1;
        if (phase_q == IDX_W'(N-1)) state_d = TALLY;
      end
      TALLY: begin
        for (int i = 0; i < N; i++) begin
          sorted_d[i]     = key_q[i];
          sorted_tag_d[i] = tag_q[i];
        end
        nth_min_d = sel_key;
        nth_tag_d = sel_tag;
        mins_d    = eq_cnt;
        valid_d   = 1'b1;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      index_q      <= '0;
      for (int i = 0; i < N; i++) begin
        key_q[i] <= '0;
        tag_q[i] <= '0;
      end
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      sorted_q     <= '0;
      sorted_tag_q <= '0;
      nth_min_q    <= '0;
      nth_tag_q    <= '0;
      mins_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      index_q      <= index_d;
      key_q        <= key_d;
      tag_q        <= tag_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      sorted_q     <= sorted_d;
      sorted_tag_q <= sorted_tag_d;
      nth_min_q    <= nth_min_d;
      nth_tag_q    <= nth_tag_d;
      mins_q       <= mins_d;
    end
  end

  assign bus.ready_out   = ready_q;
  assign bus.busy_out    = busy_q;
  assign bus.valid_out   = valid_q;
  assign bus.sorted      = sorted_q;
  assign bus.sorted_tag  = sorted_tag_q;
  assign bus.nth_min     = nth_min_q;
  assign bus.nth_tag     = nth_tag_q;
  assign bus.num_of_mins = mins_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_kth_select_sorter.sv
module tb_kth_select_sorter;
  import sort_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  kth_select_sorter_if #(.WIDTH(8),  .N(4))  if4u ();
  kth_select_sorter_if #(.WIDTH(8),  .N(4))  if4s ();
  kth_select_sorter_if #(.WIDTH(8),  .N(8))  if8  ();
  kth_select_sorter_if #(.WIDTH(16), .N(16)) if16 ();

  kth_select_sorter #(.WIDTH(8),  .N(4),  .SIGNED(0)) u4u  (.clk_in(clk), .rst_in(rst), .bus(if4u));
  kth_select_sorter #(.WIDTH(8),  .N(4),  .SIGNED(1)) u4s  (.clk_in(clk), .rst_in(rst), .bus(if4s));
  kth_select_sorter #(.WIDTH(8),  .N(8),  .SIGNED(0)) u8   (.clk_in(clk), .rst_in(rst), .bus(if8));
  kth_select_sorter #(.WIDTH(16), .N(16), .SIGNED(0)) u16  (.clk_in(clk), .rst_in(rst), .bus(if16));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint to_val(input logic [15:0] raw, input int w, input bit sgn);
    longint v;
    v = longint'(raw);
    if (sgn && raw[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Stable sort by rank counting: a key's final position is the number of keys
  // strictly smaller plus the number of equal keys that came earlier.
  function automatic void ref_model(input longint v[$], input int idx,
                                    output int ord[$], output int cnt);
    int n;
    n = v.size();
    ord = {};
    for (int i = 0; i < n; i++) ord.push_back(0);
    for (int i = 0; i < n; i++) begin
      int r;
      r = 0;
      for (int j = 0; j < n; j++)
        if (v[j] < v[i] || (v[j] == v[i] && j < i)) r++;
      ord[r] = i;
    end
    cnt = 0;
    for (int j = 0; j < n; j++) if (v[j] == v[ord[idx]]) cnt++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_4(input bit sgn, input logic [3:0][7:0] k, input logic [1:0] idx,
                         output int lat, output logic b1, output logic rdy_v);
    @(negedge clk);
    if (sgn) begin if4s.numbers = k; if4s.index = idx; if4s.valid_in = 1'b1; end
    else     begin if4u.numbers = k; if4u.index = idx; if4u.valid_in = 1'b1; end
    @(posedge clk);
    lat = -1; b1 = 1'b0; rdy_v = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if4s.valid_in = 1'b0;
      if4u.valid_in = 1'b0;
      if (c == 1) b1 = sgn ? if4s.busy_out : if4u.busy_out;
      if (sgn ? if4s.valid_out : if4u.valid_out) begin
        lat = c;
        rdy_v = sgn ? if4s.ready_out : if4u.ready_out;
        break;
      end
    end
  endtask

  task automatic drive_8(input logic [7:0][7:0] k, input logic [2:0] idx, output int lat);
    @(negedge clk);
    if8.numbers = k; if8.index = idx; if8.valid_in = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if8.valid_in = 1'b0;
      if (if8.valid_out) begin lat = c; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (if4u.ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", if4u.ready_out); end
    total++; if (if4u.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if4u.busy_out); end
    total++; if (if4u.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if4u.valid_out); end
    total++; if (if4u.state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", if4u.state_dbg, IDLE); end
    total++; if (if16.nth_min !== 16'd0 || if16.num_of_mins !== 5'd0 || if16.nth_tag !== 4'd0)
      begin bad++; $display("FAIL reset_nth got=%0h/%0d/%0d want=0/0/0", if16.nth_min, if16.num_of_mins, if16.nth_tag); end
    total++; if (if16.sorted !== '0 || if16.sorted_tag !== '0)
      begin bad++; $display("FAIL reset_sorted got=%0h/%0h want=0", if16.sorted, if16.sorted_tag); end
    total++; if (if8.ready_out !== 1'b1 || if4s.ready_out !== 1'b1 || if16.ready_out !== 1'b1)
      begin bad++; $display("FAIL reset_ready_all got=%b%b%b want=111", if8.ready_out, if4s.ready_out, if16.ready_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic_n4();
    logic [3:0][7:0] k;
    logic [7:0] es [4];
    logic [1:0] et [4];
    int lat; logic b1, rv;
    k[0] = 8'd5; k[1] = 8'd1; k[2] = 8'd4; k[3] = 8'd2;
    es = '{8'd1, 8'd2, 8'd4, 8'd5};
    et = '{2'd1, 2'd3, 2'd2, 2'd0};
    drive_4(1'b0, k, 2'd1, lat, b1, rv);
    total++; if (lat !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", lat); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy_c1 got=%b want=1", b1); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL basic_ready_at_valid got=%b want=1", rv); end
    for (int i = 0; i < 4; i++) begin
      total++; if (if4u.sorted[i] !== es[i]) begin bad++; $display("FAIL basic_sorted[%0d] got=%0d want=%0d", i, if4u.sorted[i], es[i]); end
      total++; if (if4u.sorted_tag[i] !== et[i]) begin bad++; $display("FAIL basic_tag[%0d] got=%0d want=%0d", i, if4u.sorted_tag[i], et[i]); end
    end
    total++; if (if4u.nth_min !== 8'd2) begin bad++; $display("FAIL basic_nth_min got=%0d want=2", if4u.nth_min); end
    total++; if (if4u.nth_tag !== 2'd3) begin bad++; $display("FAIL basic_nth_tag got=%0d want=3", if4u.nth_tag); end
    total++; if (if4u.num_of_mins !== 3'd1) begin bad++; $display("FAIL basic_mins got=%0d want=1", if4u.num_of_mins); end
    @(negedge clk);
    total++; if (if4u.valid_out !== 1'b0) begin bad++; $display("FAIL basic_valid_fall got=%b want=0", if4u.valid_out); end
    total++; if (if4u.nth_min !== 8'd2) begin bad++; $display("FAIL basic_hold got=%0d want=2", if4u.nth_min); end
  endtask

  task automatic test_signedness();
    logic [3:0][7:0] k;
    logic [7:0] ess [4], esu [4];
    logic [1:0] ets [4], etu [4];
    int lat; logic b1, rv;
    k[0] = 8'h80; k[1] = 8'h7F; k[2] = 8'h00; k[3] = 8'hFF;
    ess = '{8'h80, 8'hFF, 8'h00, 8'h7F}; ets = '{2'd0, 2'd3, 2'd2, 2'd1};
    esu = '{8'h00, 8'h7F, 8'h80, 8'hFF}; etu = '{2'd2, 2'd1, 2'd0, 2'd3};
    drive_4(1'b1, k, 2'd0, lat, b1, rv);
    total++; if (lat !== 6) begin bad++; $display("FAIL signed_latency got=%0d want=6", lat); end
    for (int i = 0; i < 4; i++) begin
      total++; if (if4s.sorted[i] !== ess[i] || if4s.sorted_tag[i] !== ets[i])
        begin bad++; $display("FAIL signed_sorted[%0d] got=%0h/%0d want=%0h/%0d", i, if4s.sorted[i], if4s.sorted_tag[i], ess[i], ets[i]); end
    end
    total++; if (if4s.nth_min !== 8'h80 || if4s.nth_tag !== 2'd0 || if4s.num_of_mins !== 3'd1)
      begin bad++; $display("FAIL signed_nth got=%0h/%0d/%0d want=80/0/1", if4s.nth_min, if4s.nth_tag, if4s.num_of_mins); end
    drive_4(1'b0, k, 2'd0, lat, b1, rv);
    total++; if (lat !== 6) begin bad++; $display("FAIL unsigned_latency got=%0d want=6", lat); end
    for (int i = 0; i < 4; i++) begin
      total++; if (if4u.sorted[i] !== esu[i] || if4u.sorted_tag[i] !== etu[i])
        begin bad++; $display("FAIL unsigned_sorted[%0d] got=%0h/%0d want=%0h/%0d", i, if4u.sorted[i], if4u.sorted_tag[i], esu[i], etu[i]); end
    end
    total++; if (if4u.nth_min !== 8'h00 || if4u.nth_tag !== 2'd2 || if4u.num_of_mins !== 3'd1)
      begin bad++; $display("FAIL unsigned_nth got=%0h/%0d/%0d want=0/2/1", if4u.nth_min, if4u.nth_tag, if4u.num_of_mins); end
  endtask

  task automatic test_random_signed();
    logic [3:0][7:0] k;
    logic [1:0] idx;
    longint v[$];
    int ord[$];
    int cnt, lat;
    logic b1, rv;
    for (int r = 0; r < 30; r++) begin
      v = {};
      for (int i = 0; i < 4; i++) begin
        k[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(126, 129));
        v.push_back(to_val(16'(k[i]), 8, 1'b1));
      end
      idx = 2'($urandom_range(0, 3));
      ref_model(v, int'(idx), ord, cnt);
      drive_4(1'b1, k, idx, lat, b1, rv);
      total++; if (lat !== 6) begin bad++; $display("FAIL rsigned_latency req=%0d got=%0d want=6", r, lat); end
      for (int i = 0; i < 4; i++) begin
        total++; if (if4s.sorted[i] !== k[ord[i]] || if4s.sorted_tag[i] !== 2'(ord[i]))
          begin bad++; $display("FAIL rsigned_sorted req=%0d pos=%0d got=%0h/%0d want=%0h/%0d", r, i, if4s.sorted[i], if4s.sorted_tag[i], k[ord[i]], ord[i]); end
      end
      total++; if (if4s.nth_min !== k[ord[idx]] || if4s.nth_tag !== 2'(ord[idx]) || if4s.num_of_mins !== 3'(cnt))
        begin bad++; $display("FAIL rsigned_nth req=%0d got=%0h/%0d/%0d want=%0h/%0d/%0d", r, if4s.nth_min, if4s.nth_tag, if4s.num_of_mins, k[ord[idx]], ord[idx], cnt); end
    end
  endtask

  task automatic test_all_equal();
    logic [7:0][7:0] k;
    int lat;
    for (int i = 0; i < 8; i++) k[i] = 8'd7;
    drive_8(k, 3'd5, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL equal_latency got=%0d want=10", lat); end
    total++; if (if8.nth_min !== 8'd7 || if8.nth_tag !== 3'd5)
      begin bad++; $display("FAIL equal_nth got=%0d/%0d want=7/5", if8.nth_min, if8.nth_tag); end
    total++; if (if8.num_of_mins !== 4'd8) begin bad++; $display("FAIL equal_mins got=%0d want=8", if8.num_of_mins); end
    for (int i = 0; i < 8; i++) begin
      total++; if (if8.sorted_tag[i] !== 3'(i) || if8.sorted[i] !== 8'd7)
        begin bad++; $display("FAIL equal_tag[%0d] got=%0d/%0d want=%0d/7", i, if8.sorted_tag[i], if8.sorted[i], i); end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0][7:0] ka, kb;
    logic [2:0] ia, ib;
    longint va[$], vb[$];
    int oa[$], ob[$];
    int ca, cb, lat;
    va = {}; vb = {};
    for (int i = 0; i < 8; i++) begin
      ka[i] = 8'($urandom_range(0, 15)); va.push_back(longint'(ka[i]));
      kb[i] = 8'($urandom_range(0, 255)); vb.push_back(longint'(kb[i]));
    end
    ia = 3'($urandom_range(0, 7)); ib = 3'($urandom_range(0, 7));
    ref_model(va, int'(ia), oa, ca);
    ref_model(vb, int'(ib), ob, cb);
    @(negedge clk);
    if8.numbers = ka; if8.index = ia; if8.valid_in = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if8.numbers[i] = 8'($urandom_range(0, 255));
      if8.index = 3'($urandom_range(0, 7));
      if8.valid_in = 1'b1;
      total++; if (if8.ready_out !== 1'b0 || if8.valid_out !== 1'b0)
        begin bad++; $display("FAIL bp_hold cycle=%0d got ready=%b valid=%b want ready=0 valid=0", c, if8.ready_out, if8.valid_out); end
    end
    @(negedge clk);
    total++; if (if8.valid_out !== 1'b1) begin bad++; $display("FAIL bp_valid_c10 got=%b want=1", if8.valid_out); end
    for (int i = 0; i < 8; i++) begin
      total++; if (if8.sorted[i] !== ka[oa[i]] || if8.sorted_tag[i] !== 3'(oa[i]))
        begin bad++; $display("FAIL bp_sorted_a[%0d] got=%0d/%0d want=%0d/%0d", i, if8.sorted[i], if8.sorted_tag[i], ka[oa[i]], oa[i]); end
    end
    total++; if (if8.nth_min !== ka[oa[ia]] || if8.nth_tag !== 3'(oa[ia]) || if8.num_of_mins !== 4'(ca))
      begin bad++; $display("FAIL bp_nth_a got=%0d/%0d/%0d want=%0d/%0d/%0d", if8.nth_min, if8.nth_tag, if8.num_of_mins, ka[oa[ia]], oa[ia], ca); end
    if8.numbers = kb; if8.index = ib; if8.valid_in = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 11; c <= 50; c++) begin
      @(negedge clk);
      if8.valid_in = 1'b0;
      if (if8.valid_out) begin lat = c; break; end
    end
    total++; if (lat !== 20) begin bad++; $display("FAIL bp_latency_b got=%0d want=20", lat); end
    total++; if (if8.nth_min !== kb[ob[ib]] || if8.nth_tag !== 3'(ob[ib]) || if8.num_of_mins !== 4'(cb))
      begin bad++; $display("FAIL bp_nth_b got=%0d/%0d/%0d want=%0d/%0d/%0d", if8.nth_min, if8.nth_tag, if8.num_of_mins, kb[ob[ib]], ob[ib], cb); end
  endtask

  task automatic test_reset_mid_sort();
    logic [7:0][7:0] k;
    logic [2:0] idx;
    longint v[$];
    int ord[$];
    int cnt, lat, pulses;
    for (int i = 0; i < 8; i++) k[i] = 8'($urandom_range(1, 255));
    @(negedge clk);
    if8.numbers = k; if8.index = 3'd2; if8.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk); if8.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (if8.ready_out !== 1'b1 || if8.busy_out !== 1'b0 || if8.valid_out !== 1'b0)
      begin bad++; $display("FAIL midrst_flags got r=%b b=%b v=%b want 1/0/0", if8.ready_out, if8.busy_out, if8.valid_out); end
    total++; if (if8.sorted !== '0 || if8.sorted_tag !== '0 || if8.nth_min !== 8'd0 || if8.nth_tag !== 3'd0 || if8.num_of_mins !== 4'd0)
      begin bad++; $display("FAIL midrst_results got=%0h/%0h/%0d/%0d/%0d want=0", if8.sorted, if8.sorted_tag, if8.nth_min, if8.nth_tag, if8.num_of_mins); end
    total++; if (if8.state_dbg !== IDLE) begin bad++; $display("FAIL midrst_state got=%0d want=%0d", if8.state_dbg, IDLE); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if8.valid_out) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d pulses want=0", pulses); end
    v = {};
    for (int i = 0; i < 8; i++) begin
      k[i] = 8'($urandom_range(0, 7)); v.push_back(longint'(k[i]));
    end
    idx = 3'($urandom_range(0, 7));
    ref_model(v, int'(idx), ord, cnt);
    drive_8(k, idx, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL midrst_after_latency got=%0d want=10", lat); end
    total++; if (if8.nth_min !== k[ord[idx]] || if8.nth_tag !== 3'(ord[idx]) || if8.num_of_mins !== 4'(cnt))
      begin bad++; $display("FAIL midrst_after_nth got=%0d/%0d/%0d want=%0d/%0d/%0d", if8.nth_min, if8.nth_tag, if8.num_of_mins, k[ord[idx]], ord[idx], cnt); end
  endtask

  task automatic gen_16(output logic [15:0][15:0] k, output logic [3:0] idx);
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: k[i] = 16'($urandom_range(0, 65535));
        1: k[i] = 16'($urandom_range(0, 3));
        default: begin
          case ($urandom_range(0, 4))
            0: k[i] = 16'h0000;
            1: k[i] = 16'hFFFF;
            2: k[i] = 16'h8000;
            3: k[i] = 16'h7FFF;
            default: k[i] = 16'($urandom_range(0, 65535));
          endcase
        end
      endcase
    end
    idx = 4'($urandom_range(0, 15));
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    logic [15:0][15:0] keys_q [$];
    int idx_q [$];
    logic [15:0][15:0] k, kk;
    logic [3:0] idx;
    logic [15:0] e_nth;
    longint v[$];
    int ord[$];
    int cnt, lat, ii;
    gen_16(k, idx);
    v = {}; for (int i = 0; i < 16; i++) v.push_back(to_val(k[i], 16, 1'b0));
    ref_model(v, int'(idx), ord, cnt);
    exp_q.push_back(k[ord[idx]]); keys_q.push_back(k); idx_q.push_back(int'(idx));
    @(negedge clk);
    if16.numbers = k; if16.index = idx; if16.valid_in = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if16.valid_in = 1'b0;
        if (if16.valid_out) begin lat = c; break; end
      end
      total++;
      if (lat !== 18) begin
        bad++; $display("FAIL b2b_latency req=%0d got=%0d want=18", r, lat);
        if (lat == -1) break;
      end
      e_nth = exp_q.pop_front(); kk = keys_q.pop_front(); ii = idx_q.pop_front();
      v = {}; for (int i = 0; i < 16; i++) v.push_back(to_val(kk[i], 16, 1'b0));
      ref_model(v, ii, ord, cnt);
      total++; if (if16.nth_min !== e_nth) begin bad++; $display("FAIL b2b_nth_min req=%0d got=%0h want=%0h", r, if16.nth_min, e_nth); end
      total++; if (if16.nth_tag !== 4'(ord[ii])) begin bad++; $display("FAIL b2b_nth_tag req=%0d got=%0d want=%0d", r, if16.nth_tag, ord[ii]); end
      total++; if (if16.num_of_mins !== 5'(cnt)) begin bad++; $display("FAIL b2b_mins req=%0d got=%0d want=%0d", r, if16.num_of_mins, cnt); end
      for (int i = 0; i < 16; i++) begin
        total++; if (if16.sorted[i] !== kk[ord[i]] || if16.sorted_tag[i] !== 4'(ord[i]))
          begin bad++; $display("FAIL b2b_sorted req=%0d pos=%0d got=%0h/%0d want=%0h/%0d", r, i, if16.sorted[i], if16.sorted_tag[i], kk[ord[i]], ord[i]); end
      end
      if (r < 999) begin
        gen_16(k, idx);
        v = {}; for (int i = 0; i < 16; i++) v.push_back(to_val(k[i], 16, 1'b0));
        ref_model(v, int'(idx), ord, cnt);
        exp_q.push_back(k[ord[idx]]); keys_q.push_back(k); idx_q.push_back(int'(idx));
        if16.numbers = k; if16.index = idx; if16.valid_in = 1'b1;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    if4u.numbers = '0; if4u.index = '0; if4u.valid_in = 1'b0;
    if4s.numbers = '0; if4s.index = '0; if4s.valid_in = 1'b0;
    if8.numbers  = '0; if8.index  = '0; if8.valid_in  = 1'b0;
    if16.numbers = '0; if16.index = '0; if16.valid_in = 1'b0;
    test_reset();
    test_basic_n4();
    test_signedness();
    test_random_signed();
    test_all_equal();
    test_back_pressure();
    test_reset_mid_sort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
